// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the FIFO pop streamer.
package fifo_stream_pkg;

    typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_t;

    localparam int OCC_MAX   = 2;
    localparam int PAR_MAX_W = 64;

    // Even parity: XOR reduction, callers zero-extend narrower words.
    function automatic logic parity_even(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/fifo_pop_streamer.sv
// Drains a FWFT FIFO into a valid/ready stream through a 2-entry skid buffer.
// Optional out_parity port enabled by FIFO_POP_STREAMER_PARITY_EN.
module fifo_pop_streamer
    import fifo_stream_pkg::*;
#(
    parameter int width = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [width-1:0] fifo_dout,
    input  logic             fifo_pndng,
    output logic             fifo_pop,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] words_sent,
    output logic             busy
`ifdef FIFO_POP_STREAMER_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    occ_t             occ_q, occ_d;
    logic [width-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_i, pop_o;

    // Pop only depends on registered occupancy, so out_ready never reaches the FIFO.
    assign fifo_pop   = !rst && en && fifo_pndng && (occ_q != OCC_TWO);
    assign push_i     = fifo_pop;
    assign out_valid  = (occ_q != OCC_EMPTY);
    assign pop_o      = out_valid && out_ready;
    assign out_data   = e0_q;
    assign busy       = out_valid;
    assign words_sent = cnt_q;

`ifdef FIFO_POP_STREAMER_PARITY_EN
    logic p0_q, p0_d, p1_q, p1_d, pin;
    assign pin        = parity_even(PAR_MAX_W'(fifo_dout));
    assign out_parity = p0_q;
`endif

    always_comb begin
        occ_d = occ_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
`ifdef FIFO_POP_STREAMER_PARITY_EN
        p0_d  = p0_q;
        p1_d  = p1_q;
`endif
        cnt_d = cnt_q + CNT_W'(pop_o);
        case (occ_q)
            OCC_EMPTY: if (push_i) begin
                occ_d = OCC_ONE;
                e0_d  = fifo_dout;
`ifdef FIFO_POP_STREAMER_PARITY_EN
                p0_d  = pin;
`endif
            end
            OCC_ONE: begin
                if (push_i && !pop_o) begin
                    occ_d = OCC_TWO;
                    e1_d  = fifo_dout;
`ifdef FIFO_POP_STREAMER_PARITY_EN
                    p1_d  = pin;
`endif
                end else if (push_i && pop_o) begin
                    e0_d  = fifo_dout;
`ifdef FIFO_POP_STREAMER_PARITY_EN
                    p0_d  = pin;
`endif
                end else if (pop_o) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_TWO: if (pop_o) begin
                occ_d = OCC_ONE;
                e0_d  = e1_q;
`ifdef FIFO_POP_STREAMER_PARITY_EN
                p0_d  = p1_q;
`endif
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= OCC_EMPTY;
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
`ifdef FIFO_POP_STREAMER_PARITY_EN
            p0_q  <= 1'b0;
            p1_q  <= 1'b0;
`endif
        end else begin
            occ_q <= occ_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
`ifdef FIFO_POP_STREAMER_PARITY_EN
            p0_q  <= p0_d;
            p1_q  <= p1_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_pop_streamer.sv
// Directed table-driven bench for fifo_pop_streamer with a behavioural FWFT FIFO.
module tb_fifo_pop_streamer;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, en, out_ready;
    logic [W-1:0]  fifo_dout;
    logic          fifo_pndng, fifo_pop, out_valid, busy;
    logic [W-1:0]  out_data;
    logic [CW-1:0] words_sent;
`ifdef FIFO_POP_STREAMER_PARITY_EN
    logic          out_parity;
`endif

    always #5 clk = ~clk;

    fifo_pop_streamer #(.width(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .fifo_dout(fifo_dout), .fifo_pndng(fifo_pndng), .fifo_pop(fifo_pop),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .words_sent(words_sent), .busy(busy)
`ifdef FIFO_POP_STREAMER_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    typedef struct {
        int            push;
        logic          en, rdy, pop, vld;
        logic [W-1:0]  data;
        logic [CW-1:0] cnt;
        int            fq;
    } vec_t;

    logic [W-1:0] fq[$];
    vec_t         tv[$];
    int           n_chk = 0, n_fail = 0;
    int           nw = 1;
    logic         p;

    function automatic vec_t v(int push, logic e, logic r, logic pp, logic vl,
                               logic [W-1:0] d, logic [CW-1:0] c, int f);
        vec_t t;
        t.push = push; t.en = e; t.rdy = r; t.pop = pp; t.vld = vl;
        t.data = d; t.cnt = c; t.fq = f;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_pndng = (fq.size() != 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push_val(input logic [W-1:0] d);
        fq.push_back(d);
        refresh();
    endtask

    // Samples fifo_pop just before the edge, then retires the popped head.
    task automatic tick(output logic popped);
        #1;
        popped = fifo_pop;
        @(posedge clk);
        #1;
        if (popped) void'(fq.pop_front());
        refresh();
    endtask

    initial begin
        // streaming: FIFO preloaded with 1..8
        for (int k = 1; k <= 8; k++)
            tv.push_back(v(0, 1, 1, 1, 1, W'(k), CW'(k - 1), 8 - k));
        tv.push_back(v(0, 1, 1, 0, 0, 0, 8, 0));
        tv.push_back(v(0, 1, 1, 0, 0, 0, 8, 0));
        // backpressure: exactly two pops, head held, then drain in order
        tv.push_back(v(3, 1, 0, 1, 1, 9, 8, 2));
        tv.push_back(v(0, 1, 0, 1, 1, 9, 8, 1));
        tv.push_back(v(0, 1, 0, 0, 1, 9, 8, 1));
        tv.push_back(v(0, 1, 0, 0, 1, 9, 8, 1));
        tv.push_back(v(0, 1, 1, 0, 1, 10, 9, 1));
        tv.push_back(v(0, 1, 1, 1, 1, 11, 10, 0));
        tv.push_back(v(0, 1, 1, 0, 0, 0, 11, 0));
        // enable gating: two buffered, en drops, three stay in FIFO
        tv.push_back(v(5, 1, 0, 1, 1, 12, 11, 4));
        tv.push_back(v(0, 1, 0, 1, 1, 12, 11, 3));
        tv.push_back(v(0, 0, 1, 0, 1, 13, 12, 3));
        tv.push_back(v(0, 0, 1, 0, 0, 0, 13, 3));
        tv.push_back(v(0, 0, 1, 0, 0, 0, 13, 3));
        tv.push_back(v(0, 1, 1, 1, 1, 14, 13, 2));
        tv.push_back(v(0, 1, 1, 1, 1, 15, 14, 1));
        tv.push_back(v(0, 1, 1, 1, 1, 16, 15, 0));
        tv.push_back(v(0, 1, 1, 0, 0, 0, 0, 0));
        // 17th transfer: counter wrapped to 1
        tv.push_back(v(1, 1, 1, 1, 1, 17, 0, 0));
        tv.push_back(v(0, 1, 1, 0, 0, 0, 1, 0));

        // reset with FIFO preloaded
        rst = 1'b1; en = 1'b1; out_ready = 1'b1;
        refresh();
        for (int k = 1; k <= 8; k++) push_val(W'(k));
        nw = 9;
        #1;
        chk("rst_pop", fifo_pop, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", words_sent, 0);
`ifdef FIFO_POP_STREAMER_PARITY_EN
        chk("rst_parity", out_parity, 0);
`endif
        for (int k = 0; k < 2; k++) begin
            tick(p);
            chk("rst_hold_pop", p, 0);
            chk("rst_hold_valid", out_valid, 0);
            chk("rst_hold_fq", fq.size(), 8);
        end
        rst = 1'b0;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_cnt", words_sent, 0);

        for (int i = 0; i < tv.size(); i++) begin
            for (int k = 0; k < tv[i].push; k++) begin
                push_val(W'(nw));
                nw++;
            end
            en = tv[i].en; out_ready = tv[i].rdy;
            tick(p);
            chk($sformatf("v%0d_pop", i), p, tv[i].pop);
            chk($sformatf("v%0d_valid", i), out_valid, tv[i].vld);
            chk($sformatf("v%0d_busy", i), busy, tv[i].vld);
            if (tv[i].vld) chk($sformatf("v%0d_data", i), out_data, tv[i].data);
            chk($sformatf("v%0d_cnt", i), words_sent, tv[i].cnt);
            chk($sformatf("v%0d_fq", i), fq.size(), tv[i].fq);
        end

        // mid-operation async reset while two words are buffered
        push_val(16'h0007); push_val(16'h0003); push_val(16'h00AA);
        en = 1'b1; out_ready = 1'b0;
        tick(p);
        chk("mr_data0", out_data, 16'h0007);
        tick(p);
        chk("mr_pop2", p, 1);
        chk("mr_valid", out_valid, 1);
        chk("mr_fq", fq.size(), 1);
        #2 rst = 1'b1;
        #1;
        chk("mr_async_valid", out_valid, 0);
        chk("mr_async_busy", busy, 0);
        chk("mr_async_cnt", words_sent, 0);
        chk("mr_async_pop", fifo_pop, 0);
        tick(p);
        chk("mr_hold_pop", p, 0);
        rst = 1'b0; out_ready = 1'b1;
        tick(p);
        chk("mr_rel_pop", p, 1);
        chk("mr_rel_valid", out_valid, 1);
        chk("mr_rel_data", out_data, 16'h00AA);
        chk("mr_rel_cnt", words_sent, 0);
        tick(p);
        chk("mr_drain_valid", out_valid, 0);
        chk("mr_drain_cnt", words_sent, 1);

`ifdef FIFO_POP_STREAMER_PARITY_EN
        push_val(16'h0007); push_val(16'h0003);
        tick(p);
        chk("par_data7", out_data, 16'h0007);
        chk("par_7", out_parity, 1);
        tick(p);
        chk("par_data3", out_data, 16'h0003);
        chk("par_3", out_parity, 0);
        tick(p);
        chk("par_drain_cnt", words_sent, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_pop_streamer.md
Name: fifo_pop_streamer

Overview:
Downstream consumer of fifo_flops. Drains the FIFO through its pop/pndng interface and re-presents each word on a valid/ready output stream. A 2-entry skid buffer keeps fifo_pop independent of out_ready, so there is no combinational path from the sink to the FIFO. Sits between the FIFO and any stream sink (checker/scoreboard-side monitor, serializer, etc.).

Parameters:
width, 16, data word width; matches fifo_flops bits
CNT_W, 16, width of the delivered-word counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  drain enable; 0 = stop issuing pops
fifo_dout  in  width  FIFO head word (fifo_flops Dout)
fifo_pndng  in  1  FIFO not-empty (fifo_flops pndng)
fifo_pop  out  1  pop strobe to FIFO (combinational)
out_data  out  width  stream data
out_valid  out  1  stream valid
out_ready  in  1  stream ready from sink
words_sent  out  CNT_W  count of accepted output transfers
busy  out  1  skid buffer holds at least one word

Behaviour:
- FIFO contract: fifo_dout is valid whenever fifo_pndng=1 (first-word fall-through). fifo_pop=1 on a rising edge removes the head; the word on fifo_dout in that cycle is the popped word.
- Internal state:
  - occ ∈ {EMPTY, ONE, TWO}.
  - Entries e0 (head, drives out_data) and e1.
- fifo_pop = !rst && en && fifo_pndng && (occ != TWO). It depends only on registered state and FIFO/enable inputs, never on out_ready.
- Events:
  - push_i = fifo_pop.
  - pop_o = out_valid && out_ready (transfer).
- out_valid = (occ != EMPTY). out_data = e0. busy = out_valid.
- Transitions on the clk edge:
  - EMPTY: push_i → ONE, e0 ← fifo_dout.
  - ONE, push_i only: → TWO, e1 ← fifo_dout.
  - ONE, pop_o only: → EMPTY.
  - ONE, push_i and pop_o: stay ONE, e0 ← fifo_dout.
  - TWO, pop_o: → ONE, e0 ← e1. No push is possible in TWO.
  - TWO, no pop_o: hold. out_data and out_valid stay stable while valid && !ready (AXI-style stability).
- Latency: FIFO word popped at edge N appears on out_data from edge N onward, i.e. registered, one cycle after the pop cycle.
- Throughput: 1 word/cycle sustained while pndng=1, en=1 and out_ready=1.
- words_sent:
  - Increments by 1 on each pop_o.
  - Wraps modulo 2^CNT_W.
- en=0 mid-operation: pops stop next cycle (combinational). Words already buffered are still delivered.
- FIFO empty (pndng=0): no pop. A buffer that drains goes EMPTY and out_valid drops.
- Reset (async, any time):
  - occ=EMPTY, out_valid=0, busy=0, words_sent=0, fifo_pop=0, e0=e1=0.
  - Buffered words are discarded.

Optional Feature:
Macro: FIFO_POP_STREAMER_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = even parity (XOR reduction) of out_data.
  - Parity is computed at capture and stored per entry alongside it, so it is stable with out_data.
  - Reset value 0.
- Undefined: port and storage absent. Behaviour is otherwise identical.

Decomposition:
- Package fifo_stream_pkg:
  - typedef enum logic [1:0] occ_t {OCC_EMPTY, OCC_ONE, OCC_TWO}.
  - localparam OCC_MAX=2.
- Single module; no sub-module required.
- The parity function (parity_even) lives in the package.

Test Plan:
- Reset: rst=1 with FIFO preloaded → fifo_pop=0, out_valid=0, words_sent=0 during and after reset until the first clk edge with en=1.
- Streaming: push 0x0001..0x0008 into depth-8 FIFO, en=1, out_ready=1 → out_data 0x0001..0x0008 on 8 consecutive cycles; words_sent=8; pndng falls to 0; out_valid falls 1 cycle later.
- Backpressure: out_ready=0 with 3 words in FIFO → exactly 2 pops, occ=TWO, out_data=first word held stable; release ready → remaining 3 words delivered in order, no loss or duplication.
- Enable gating: deassert en after 2 pops with 5 words queued → fifo_pop stays 0; 2 buffered words delivered; FIFO keeps 3, pndng=1.
- Mid-op reset: assert rst asynchronously (between edges) while occ=TWO → out_valid and busy drop immediately; words_sent=0; after release the next FIFO head is delivered first.
- Counter wrap, CNT_W=4 → after 17 transfers words_sent=1; with PARITY_EN, word 0x0007 → out_parity=1, 0x0003 → out_parity=0.
